// File: rtl/alu_reg_seq_if.sv
// Request and MIPS_REG port bundle for the ALU register sequencer.
// The master side issues requests and models the register file; the slave side is the sequencer.
interface alu_reg_seq_if;
    logic        Start;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [2:0]  ALU_OP;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic [31:0] Result;
    logic        ZF;
    logic        OF;
    logic        Busy;
    logic        Done;

    modport master (
        output Start, Rs, Rt, Rd, ALU_OP, R_Data_A, R_Data_B,
        input  R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, Result, ZF, OF, Busy, Done
    );

    modport slave (
        input  Start, Rs, Rt, Rd, ALU_OP, R_Data_A, R_Data_B,
        output R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, Result, ZF, OF, Busy, Done
    );
endinterface

// File: rtl/alu_reg_seq.sv
// Runs one register-to-register ALU operation per request: read, execute, write back.
// state | meaning
// IDLE  | waiting for Start; request fields captured on accept
// READ  | read ports driven from captured Rs/Rt; operands latched at edge
// EXEC  | ALU evaluates latched operands; Result/ZF/OF latched at edge
// WB    | write port presents Rd/Result; Done high, Write_Reg high unless Rd == 0
module alu_reg_seq (
    input  logic         Clk,
    input  logic         Reset,
    alu_reg_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        zf_q, zf_d;
    logic        of_q, of_d;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic        alu_of;

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = 32'd0;
        alu_of  = 1'b0;
        case (op_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: alu_res = a_q ^ b_q;
            3'b011: alu_res = ~(a_q | b_q);
            3'b100: begin
                alu_res = sum;
                alu_of  = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
            end
            3'b101: begin
                alu_res = diff;
                alu_of  = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
            end
            3'b110: alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
            3'b111: alu_res = b_q << a_q[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zf_d     = zf_q;
        of_d     = of_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    rs_d    = bus.Rs;
                    rt_d    = bus.Rt;
                    rd_d    = bus.Rd;
                    op_d    = bus.ALU_OP;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                a_d     = bus.R_Data_A;
                b_d     = bus.R_Data_B;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_res;
                zf_d     = (alu_res == 32'd0);
                of_d     = alu_of;
                state_d  = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            zf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            of_q     <= of_d;
        end
    end

    // Write enable is decoded from state so an async reset drops it in the same cycle.
    assign bus.R_Addr_A  = rs_q;
    assign bus.R_Addr_B  = rt_q;
    assign bus.W_Addr    = rd_q;
    assign bus.W_Data    = result_q;
    assign bus.Result    = result_q;
    assign bus.ZF        = zf_q;
    assign bus.OF        = of_q;
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Done      = (state_q == ST_WB);
    assign bus.Write_Reg = (state_q == ST_WB) && (rd_q != 5'd0);
endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed bench for alu_reg_seq against a behavioural 32x32 register file model.
module tb_alu_reg_seq;
    logic Clk;
    logic Reset;

    alu_reg_seq_if bus ();

    alu_reg_seq dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    logic [31:0] regs [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    int          total;
    int          bad;
    logic        wr_seen;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign bus.R_Data_A = (bus.R_Addr_A == 5'd0) ? 32'd0 : regs[bus.R_Addr_A];
    assign bus.R_Data_B = (bus.R_Addr_B == 5'd0) ? 32'd0 : regs[bus.R_Addr_B];

    always @(posedge Clk) begin
        if (bus.Write_Reg) regs[bus.W_Addr] <= bus.W_Data;
        if (pl_en) regs[pl_addr] <= pl_data;
    end

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge Clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge Clk);
        pl_en   = 1'b0;
    endtask

    // Leaves the bench at the negedge inside the WB cycle.
    task automatic launch(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.ALU_OP = op;
        bus.Rs     = rs;
        bus.Rt     = rt;
        bus.Rd     = rd;
        wr_seen    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            bus.Start = 1'b0;
            wr_seen   = wr_seen | bus.Write_Reg;
        end
    endtask

    task automatic finish_op();
        @(negedge Clk);
        wr_seen = wr_seen | bus.Write_Reg;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        wr_seen    = 1'b0;
        pl_en      = 1'b0;
        pl_addr    = 5'd0;
        pl_data    = 32'd0;
        bus.Start  = 1'b0;
        bus.Rs     = 5'd0;
        bus.Rt     = 5'd0;
        bus.Rd     = 5'd0;
        bus.ALU_OP = 3'd0;
        Reset      = 1'b0;
        #1 Reset   = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_wdata", bus.W_Data, 32'd0);
        chk("rst_waddr", {27'd0, bus.W_Addr}, 32'd0);
        Reset = 1'b0;

        preload(5'd1, 32'h2345_2345);
        preload(5'd2, 32'h1111_1111);
        preload(5'd5, 32'h7FFF_FFFF);
        preload(5'd6, 32'h0000_0001);
        preload(5'd8, 32'hFFFF_FFFF);
        preload(5'd11, 32'hDEAD_BEEF);

        // 1: ADD r1+r2 -> r3
        launch(3'b100, 5'd1, 5'd2, 5'd3);
        chk("t1_wr", {31'd0, bus.Write_Reg}, 32'd1);
        chk("t1_waddr", {27'd0, bus.W_Addr}, 32'd3);
        chk("t1_wdata", bus.W_Data, 32'h3456_3456);
        chk("t1_flags", {29'd0, bus.ZF, bus.OF, bus.Done}, 32'd1);
        finish_op();
        chk("t1_r3", rd_reg(5'd3), 32'h3456_3456);
        chk("t1_idle", {31'd0, bus.Busy}, 32'd0);

        // 2: SUB r1-r1 -> r4
        launch(3'b101, 5'd1, 5'd1, 5'd4);
        chk("t2_res", bus.Result, 32'd0);
        chk("t2_zf_of", {30'd0, bus.ZF, bus.OF}, 32'd2);
        finish_op();
        chk("t2_r4", rd_reg(5'd4), 32'd0);

        // 3: ADD overflow r5+r6 -> r7
        launch(3'b100, 5'd5, 5'd6, 5'd7);
        chk("t3_res", bus.Result, 32'h8000_0000);
        chk("t3_zf_of", {30'd0, bus.ZF, bus.OF}, 32'd1);
        finish_op();
        chk("t3_r7", rd_reg(5'd7), 32'h8000_0000);

        // 4: SLT r8<r6 into r0, no write
        launch(3'b110, 5'd8, 5'd6, 5'd0);
        chk("t4_res", bus.Result, 32'd1);
        chk("t4_done", {31'd0, bus.Done}, 32'd1);
        finish_op();
        chk("t4_nowr", {31'd0, wr_seen}, 32'd0);

        // 5: Start held high, two ops 4 cycles apart
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.ALU_OP = 3'b001;
        bus.Rs     = 5'd1;
        bus.Rt     = 5'd2;
        bus.Rd     = 5'd9;
        @(negedge Clk);
        chk("t5_busy1", {31'd0, bus.Busy}, 32'd1);
        bus.ALU_OP = 3'b111;
        bus.Rs     = 5'd6;
        bus.Rt     = 5'd9;
        bus.Rd     = 5'd10;
        @(negedge Clk);
        chk("t5_addr_held", {27'd0, bus.R_Addr_A}, 32'd1);
        @(negedge Clk);
        chk("t5_wb1", {31'd0, bus.Done}, 32'd1);
        chk("t5_wdata1", bus.W_Data, 32'h3355_3355);
        @(negedge Clk);
        chk("t5_gap", {30'd0, bus.Busy, bus.Done}, 32'd0);
        chk("t5_r9", rd_reg(5'd9), 32'h3355_3355);
        @(negedge Clk);
        chk("t5_addr2", {22'd0, bus.R_Addr_A, bus.R_Addr_B}, {22'd0, 5'd6, 5'd9});
        @(negedge Clk);
        chk("t5_exec_nodone", {31'd0, bus.Done}, 32'd0);
        @(negedge Clk);
        chk("t5_wb2", {31'd0, bus.Done}, 32'd1);
        chk("t5_wdata2", bus.W_Data, 32'h66AA_66AA);
        chk("t5_waddr2", {27'd0, bus.W_Addr}, 32'd10);
        bus.Start = 1'b0;
        @(negedge Clk);
        chk("t5_r10", rd_reg(5'd10), 32'h66AA_66AA);

        // 6: reset mid-EXEC aborts write to r11
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.ALU_OP = 3'b100;
        bus.Rs     = 5'd1;
        bus.Rt     = 5'd2;
        bus.Rd     = 5'd11;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        chk("t6_exec_busy", {31'd0, bus.Busy}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("t6_rst_wr", {31'd0, bus.Write_Reg}, 32'd0);
        chk("t6_rst_addr", {17'd0, bus.R_Addr_A, bus.R_Addr_B, bus.W_Addr}, 32'd0);
        @(negedge Clk);
        chk("t6_rst_res", bus.Result, 32'd0);
        chk("t6_rst_flags", {30'd0, bus.ZF, bus.OF}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("t6_r11", rd_reg(5'd11), 32'hDEAD_BEEF);
        launch(3'b010, 5'd1, 5'd2, 5'd12);
        chk("t6_wdata", bus.W_Data, 32'h3254_3254);
        chk("t6_wr", {31'd0, bus.Write_Reg}, 32'd1);
        finish_op();
        chk("t6_r12", rd_reg(5'd12), 32'h3254_3254);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_reg_seq.md
# alu_reg_seq

Sequencer that executes one register-to-register ALU operation per request against the MIPS_REG register file. It sits directly in front of MIPS_REG and drives its read ports. It latches the operands, computes the ALU result and flags, then drives the write port to commit the result. It is the datapath control stage for the ALU + register-file experiment.

## Interface
- No parameters; address width fixed at 5, data width fixed at 32.

- Clk  in  1  single system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Start  in  1  request strobe; sampled only in IDLE
- Rs  in  5  operand A register address
- Rt  in  5  operand B register address
- Rd  in  5  destination register address
- ALU_OP  in  3  operation select
- R_Addr_A  out  5  to MIPS_REG read port A
- R_Addr_B  out  5  to MIPS_REG read port B
- R_Data_A  in  32  from MIPS_REG, combinational read
- R_Data_B  in  32  from MIPS_REG, combinational read
- W_Addr  out  5  to MIPS_REG write address
- W_Data  out  32  to MIPS_REG write data
- Write_Reg  out  1  to MIPS_REG write enable
- Result  out  32  registered ALU result of the last operation
- ZF  out  1  registered zero flag (Result == 0)
- OF  out  1  registered signed-overflow flag
- Busy  out  1  high whenever state != IDLE
- Done  out  1  high for exactly the WB cycle

## Operation
- Moore FSM with states IDLE, READ, EXEC, WB.
- **IDLE.** If Start=1 at the edge, capture Rs, Rt, Rd and ALU_OP into internal registers and go to READ. Otherwise stay in IDLE.
- **READ.** R_Addr_A and R_Addr_B are driven from the captured Rs and Rt. At the edge, latch R_Data_A and R_Data_B into operand registers A and B, then go to EXEC.
- **EXEC.** Compute the operation from A and B. At the edge, latch Result, ZF and OF, then go to WB.
- **WB.** W_Addr is the captured Rd and W_Data is Result. Done=1.
  - Write_Reg=1 only if captured Rd != 0.
  - If Rd = 0, Write_Reg stays 0, but Result, ZF, OF and Done still update.
  - Go to IDLE at the edge.
- R_Addr_A and R_Addr_B hold the captured Rs and Rt in every state. W_Addr holds the captured Rd. W_Data always equals Result. Write_Reg is low outside WB.
- ALU_OP encoding:
  - 000 AND; 001 OR; 010 XOR; 011 NOR
  - 100 ADD; 101 SUB (A−B)
  - 110 SLT: Result = 1 if A < B signed, else 0
  - 111 SLL: Result = B << A[4:0]
- Arithmetic is 32-bit wrap-around; carry-out is discarded.
- OF applies to ADD and SUB only; it is 0 for all other ops.
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
- Overflowed results are still written back.
- Start while Busy=1 is ignored; the request is not queued.

## Timing
- Edge 0 samples Start. The READ cycle follows, then EXEC, then WB. MIPS_REG commits the write at the edge that ends WB (edge 3 after edge 0).
- Latency from Start sample to write commit is 3 cycles.
- Maximum throughput is one operation per 4 cycles, because at least one IDLE cycle occurs between operations.
- A following operation's READ occurs after the previous write has committed. Dependent back-to-back operations therefore read the new value, and no forwarding is needed.
- Reset values, applied asynchronously on assertion:
  - state IDLE
  - captured Rs, Rt, Rd and ALU_OP = 0, so R_Addr_A, R_Addr_B and W_Addr = 0
  - A = B = 0; Result = 0, hence W_Data = 0
  - ZF = 0, OF = 0, Write_Reg = 0, Busy = 0, Done = 0
- Reset during any state aborts the operation. Write_Reg drops within the same cycle, so no partial write occurs.
- After Reset deasserts, the first Start is accepted normally.

## Test plan
The bench uses a behavioural 32×32 register model with combinational read, write on the rising edge, and r0 reading 0.

1. Preload r1=0x2345_2345 and r2=0x1111_1111. Start ADD Rs=1, Rt=2, Rd=3 → in the WB cycle (3rd cycle after the Start edge): Write_Reg=1, W_Addr=3, W_Data=0x3456_3456, ZF=0, OF=0, Done=1. r3 reads 0x3456_3456 afterwards.
2. SUB Rs=1, Rt=1, Rd=4 → Result=0, ZF=1, OF=0, and r4 is written with 0.
3. r5=0x7FFF_FFFF, r6=1. ADD Rd=7 → Result=0x8000_0000, OF=1, ZF=0, and r7 is still written.
4. r8=0xFFFF_FFFF, r6=1. SLT Rs=8, Rt=6, Rd=0 → Result=1, Done pulses, and Write_Reg stays 0 through the whole operation.
5. Hold Start=1 continuously.
   - Op 1: OR r1|r2 → r9 = 0x3355_3355.
   - Op 2: SLL Rs=6, Rt=9 → r10 = 0x66AA_66AA.
   - Check that op 2 reads the new r9, that Start pulses during Busy are ignored, and that operations are exactly 4 cycles apart.
6. Start ADD into r11, then assert Reset mid-EXEC → all outputs go to their reset values immediately, r11 is unchanged, and a following XOR r1^r2 → r12 = 0x3254_3254 completes normally.
